// File: rtl/lap_tracker.sv
// Lap/checkpoint tracker for one car: checkpoint windows on flattened ports,
// optional ordered checkpoints, lap counting to race completion, lap timing.

// Inclusive, unsigned containment test of the car box against one window.
module lap_tracker_win #(
  parameter int COORD_W = 11
) (
  input  logic [COORD_W-1:0] car_x_start,
  input  logic [COORD_W-1:0] car_x_end,
  input  logic [COORD_W-1:0] car_y_start,
  input  logic [COORD_W-1:0] car_y_end,
  input  logic [COORD_W-1:0] x_min,
  input  logic [COORD_W-1:0] x_max,
  input  logic [COORD_W-1:0] y_min,
  input  logic [COORD_W-1:0] y_max,
  output logic               hit
);
  assign hit = (car_x_start >= x_min) && (car_x_end <= x_max) &&
               (car_y_start >= y_min) && (car_y_end <= y_max);
endmodule

module lap_tracker #(
  parameter int N_CP      = 6,
  parameter int COORD_W   = 11,
  parameter int LAP_W     = 4,
  parameter int RACE_LAPS = 3,
  parameter int TIME_W    = 16,
  parameter int ORDERED   = 0
) (
  input  logic                    pclk,
  input  logic                    rst,
  input  logic [COORD_W-1:0]      car_x_start,
  input  logic [COORD_W-1:0]      car_x_end,
  input  logic [COORD_W-1:0]      car_y_start,
  input  logic [COORD_W-1:0]      car_y_end,
  input  logic [COORD_W-1:0]      fin_x_min,
  input  logic [COORD_W-1:0]      fin_x_max,
  input  logic [COORD_W-1:0]      fin_y_min,
  input  logic [COORD_W-1:0]      fin_y_max,
  input  logic [N_CP*COORD_W-1:0] cp_x_min,
  input  logic [N_CP*COORD_W-1:0] cp_x_max,
  input  logic [N_CP*COORD_W-1:0] cp_y_min,
  input  logic [N_CP*COORD_W-1:0] cp_y_max,
  input  logic                    time_tick,
  output logic [N_CP-1:0]         cp_mask,
  output logic                    checkpoints_passed,
  output logic                    lap_finished,
  output logic [LAP_W-1:0]        lap_count,
  output logic                    race_done,
  output logic [TIME_W-1:0]       lap_time,
  output logic [TIME_W-1:0]       last_lap_time,
  output logic [TIME_W-1:0]       best_lap_time
);
  typedef enum logic [1:0] {WAIT_START, RACING, DONE} state_t;

  localparam int                CNT_W    = $clog2(N_CP + 1);
  localparam logic [LAP_W-1:0]  LAP_ONE  = LAP_W'(1);
  localparam logic [LAP_W-1:0]  LAP_LAST = LAP_W'(RACE_LAPS);
  localparam logic [TIME_W-1:0] TIME_ONE = TIME_W'(1);

  state_t            state;
  logic              in_fin, in_fin_q, fin_edge;
  logic [N_CP-1:0]   cp_hit, cp_set;
  logic [CNT_W-1:0]  n_set;
  logic [TIME_W-1:0] lap_time_nxt;

  lap_tracker_win #(.COORD_W(COORD_W)) u_fin (
    .car_x_start(car_x_start), .car_x_end(car_x_end),
    .car_y_start(car_y_start), .car_y_end(car_y_end),
    .x_min(fin_x_min), .x_max(fin_x_max),
    .y_min(fin_y_min), .y_max(fin_y_max),
    .hit(in_fin)
  );

  for (genvar i = 0; i < N_CP; i++) begin : g_cp
    lap_tracker_win #(.COORD_W(COORD_W)) u_win (
      .car_x_start(car_x_start), .car_x_end(car_x_end),
      .car_y_start(car_y_start), .car_y_end(car_y_end),
      .x_min(cp_x_min[i*COORD_W +: COORD_W]),
      .x_max(cp_x_max[i*COORD_W +: COORD_W]),
      .y_min(cp_y_min[i*COORD_W +: COORD_W]),
      .y_max(cp_y_max[i*COORD_W +: COORD_W]),
      .hit(cp_hit[i])
    );
  end

  // Only the rising edge of finish occupancy counts; parking on the line is inert.
  assign fin_edge           = in_fin & ~in_fin_q;
  assign checkpoints_passed = &cp_mask;
  assign race_done          = (state == DONE);

  // Checkpoint acceptance: all hits, or in ordered mode only the next index in
  // sequence (the mask is always a contiguous run from bit 0, so the popcount
  // is the index of the lowest clear bit).
  always_comb begin
    n_set  = '0;
    cp_set = '0;
    for (int i = 0; i < N_CP; i++) n_set = n_set + CNT_W'(cp_mask[i]);
    for (int i = 0; i < N_CP; i++) begin
      if (ORDERED != 0) cp_set[i] = cp_hit[i] && (n_set == CNT_W'(i));
      else              cp_set[i] = cp_hit[i];
    end
  end

  // Saturating lap timer increment; this value is also what a lap records.
  always_comb begin
    lap_time_nxt = lap_time;
    if (time_tick && (lap_time != '1)) lap_time_nxt = lap_time + TIME_ONE;
  end

  // Race FSM with all outputs registered; a counted lap beats checkpoint hits.
  always_ff @(posedge pclk) begin
    if (!rst) begin
      state         <= WAIT_START;
      in_fin_q      <= 1'b0;
      cp_mask       <= '0;
      lap_finished  <= 1'b0;
      lap_count     <= '0;
      lap_time      <= '0;
      last_lap_time <= '0;
      best_lap_time <= '1;
    end else begin
      in_fin_q     <= in_fin;
      lap_finished <= 1'b0;
      case (state)
        WAIT_START: begin
          if (fin_edge) begin
            state    <= RACING;
            lap_time <= '0;
          end
        end
        RACING: begin
          if (fin_edge && checkpoints_passed) begin
            lap_finished  <= 1'b1;
            lap_count     <= lap_count + LAP_ONE;
            cp_mask       <= '0;
            lap_time      <= '0;
            last_lap_time <= lap_time_nxt;
            if (lap_time_nxt < best_lap_time) best_lap_time <= lap_time_nxt;
            if (lap_count + LAP_ONE == LAP_LAST) state <= DONE;
          end else begin
            lap_time <= lap_time_nxt;
            cp_mask  <= cp_mask | cp_set;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_lap_tracker.sv
// Directed bench: three tracker instances share car/window stimulus, each with
// its own reset (A: unordered 16-bit timer, B: ordered, C: 4-bit timer).
module tb_lap_tracker;
  localparam int N  = 6;
  localparam int CW = 11;

  logic pclk = 1'b0;
  always #5 pclk = ~pclk;

  logic rst_a, rst_b, rst_c;
  logic [CW-1:0] car_x_start, car_x_end, car_y_start, car_y_end;
  logic [CW-1:0] fin_x_min, fin_x_max, fin_y_min, fin_y_max;
  logic [N*CW-1:0] cp_x_min, cp_x_max, cp_y_min, cp_y_max;
  logic time_tick;

  logic [N-1:0] a_mask, b_mask, c_mask;
  logic a_pass, b_pass, c_pass, a_fin, b_fin, c_fin, a_done, b_done, c_done;
  logic [3:0] a_laps, b_laps, c_laps;
  logic [15:0] a_time, a_last, a_best, b_time, b_last, b_best;
  logic [3:0] c_time, c_last, c_best;

  int checks = 0;
  int failures = 0;
  int pulses;

  lap_tracker #(.N_CP(N), .COORD_W(CW), .LAP_W(4), .RACE_LAPS(3), .TIME_W(16), .ORDERED(0)) u_a (
    .pclk(pclk), .rst(rst_a),
    .car_x_start(car_x_start), .car_x_end(car_x_end), .car_y_start(car_y_start), .car_y_end(car_y_end),
    .fin_x_min(fin_x_min), .fin_x_max(fin_x_max), .fin_y_min(fin_y_min), .fin_y_max(fin_y_max),
    .cp_x_min(cp_x_min), .cp_x_max(cp_x_max), .cp_y_min(cp_y_min), .cp_y_max(cp_y_max),
    .time_tick(time_tick), .cp_mask(a_mask), .checkpoints_passed(a_pass), .lap_finished(a_fin),
    .lap_count(a_laps), .race_done(a_done), .lap_time(a_time), .last_lap_time(a_last), .best_lap_time(a_best)
  );

  lap_tracker #(.N_CP(N), .COORD_W(CW), .LAP_W(4), .RACE_LAPS(3), .TIME_W(16), .ORDERED(1)) u_b (
    .pclk(pclk), .rst(rst_b),
    .car_x_start(car_x_start), .car_x_end(car_x_end), .car_y_start(car_y_start), .car_y_end(car_y_end),
    .fin_x_min(fin_x_min), .fin_x_max(fin_x_max), .fin_y_min(fin_y_min), .fin_y_max(fin_y_max),
    .cp_x_min(cp_x_min), .cp_x_max(cp_x_max), .cp_y_min(cp_y_min), .cp_y_max(cp_y_max),
    .time_tick(time_tick), .cp_mask(b_mask), .checkpoints_passed(b_pass), .lap_finished(b_fin),
    .lap_count(b_laps), .race_done(b_done), .lap_time(b_time), .last_lap_time(b_last), .best_lap_time(b_best)
  );

  lap_tracker #(.N_CP(N), .COORD_W(CW), .LAP_W(4), .RACE_LAPS(3), .TIME_W(4), .ORDERED(0)) u_c (
    .pclk(pclk), .rst(rst_c),
    .car_x_start(car_x_start), .car_x_end(car_x_end), .car_y_start(car_y_start), .car_y_end(car_y_end),
    .fin_x_min(fin_x_min), .fin_x_max(fin_x_max), .fin_y_min(fin_y_min), .fin_y_max(fin_y_max),
    .cp_x_min(cp_x_min), .cp_x_max(cp_x_max), .cp_y_min(cp_y_min), .cp_y_max(cp_y_max),
    .time_tick(time_tick), .cp_mask(c_mask), .checkpoints_passed(c_pass), .lap_finished(c_fin),
    .lap_count(c_laps), .race_done(c_done), .lap_time(c_time), .last_lap_time(c_last), .best_lap_time(c_best)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge pclk);
  endtask

  // Place the 10x10 car box at (x,y) and let one active edge see it.
  task automatic goto(input int x, input int y);
    car_x_start = CW'(x);
    car_x_end   = CW'(x + 10);
    car_y_start = CW'(y);
    car_y_end   = CW'(y + 10);
    cyc();
  endtask

  task automatic home();    goto(1000, 1000); endtask
  task automatic on_fin();  goto(20, 20);     endtask
  task automatic cp(input int i); goto(110 + 100 * i, 110); endtask

  task automatic ticks(input int n);
    repeat (n) begin
      time_tick = 1'b1;
      cyc();
      time_tick = 1'b0;
    end
  endtask

  task automatic fin_normal();
    fin_x_min = 0; fin_x_max = 50; fin_y_min = 0; fin_y_max = 50;
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    time_tick = 1'b0;
    fin_normal();
    for (int i = 0; i < N; i++) begin
      cp_x_min[i*CW +: CW] = CW'(100 + 100 * i);
      cp_x_max[i*CW +: CW] = CW'(150 + 100 * i);
      cp_y_min[i*CW +: CW] = CW'(100);
      cp_y_max[i*CW +: CW] = CW'(150);
    end
    home();
    cyc();

    // Reset values
    chk("rst_mask", a_mask, 0);
    chk("rst_pass", a_pass, 0);
    chk("rst_fin", a_fin, 0);
    chk("rst_laps", a_laps, 0);
    chk("rst_done", a_done, 0);
    chk("rst_time", a_time, 0);
    chk("rst_last", a_last, 0);
    chk("rst_best", a_best, 16'hFFFF);
    chk("rst_best_c", c_best, 4'hF);

    rst_a = 1'b1;
    // WAIT_START ignores checkpoints and the timer
    cp(0);
    ticks(3);
    chk("wait_mask", a_mask, 0);
    chk("wait_time", a_time, 0);

    // Start the race
    home();
    on_fin();
    chk("start_fin", a_fin, 0);
    chk("start_time", a_time, 0);

    // Lap 1: all checkpoints, 10 ticks
    cp(0); ticks(2); cp(1); ticks(2); cp(2); ticks(2);
    cp(3); ticks(2); cp(4); ticks(1); cp(5); ticks(1);
    chk("l1_mask", a_mask, 6'h3F);
    chk("l1_pass", a_pass, 1);
    chk("l1_time", a_time, 10);
    home();
    on_fin();
    chk("l1_fin", a_fin, 1);
    chk("l1_laps", a_laps, 1);
    chk("l1_last", a_last, 10);
    chk("l1_best", a_best, 10);
    chk("l1_mask_clr", a_mask, 0);
    chk("l1_time_clr", a_time, 0);

    // Dwell on the finish line: no further pulses
    pulses = 0;
    for (int k = 0; k < 50; k++) begin
      cyc();
      if (a_fin) pulses++;
    end
    chk("dwell_pulses", pulses, 0);
    chk("dwell_laps", a_laps, 1);

    // Lap 2: shortcut (cp5 skipped) is rejected and progress kept
    home();
    cp(0); ticks(2); cp(1); ticks(2); cp(2); ticks(1); cp(3); ticks(1); cp(4); ticks(1);
    chk("sc_mask", a_mask, 6'h1F);
    home();
    on_fin();
    chk("sc_fin", a_fin, 0);
    chk("sc_laps", a_laps, 1);
    chk("sc_mask_kept", a_mask, 6'h1F);
    chk("sc_time", a_time, 7);
    home();
    cp(5);
    chk("sc_mask_full", a_mask, 6'h3F);
    home();
    // Tick arriving on the crossing edge is part of the lap
    car_x_start = 20; car_x_end = 30; car_y_start = 20; car_y_end = 30;
    time_tick = 1'b1;
    cyc();
    time_tick = 1'b0;
    chk("l2_fin", a_fin, 1);
    chk("l2_laps", a_laps, 2);
    chk("l2_last", a_last, 8);
    chk("l2_best", a_best, 8);
    chk("l2_time_clr", a_time, 0);

    // Lap 3: finish window overlaps cp0; lap wins, cp0 hit discarded
    home();
    cp(0); ticks(2); cp(1); ticks(2); cp(2); ticks(2);
    cp(3); ticks(1); cp(4); ticks(1); cp(5); ticks(1);
    fin_x_min = 100; fin_x_max = 150; fin_y_min = 100; fin_y_max = 150;
    home();
    cp(0);
    chk("l3_fin", a_fin, 1);
    chk("l3_laps", a_laps, 3);
    chk("l3_mask", a_mask, 0);
    chk("l3_last", a_last, 9);
    chk("l3_best", a_best, 8);
    chk("l3_done", a_done, 1);

    // DONE: frozen
    fin_normal();
    home();
    ticks(5);
    on_fin();
    chk("done_fin", a_fin, 0);
    chk("done_time", a_time, 0);
    chk("done_laps", a_laps, 3);
    cp(0);
    chk("done_mask", a_mask, 0);
    chk("done_level", a_done, 1);

    // Reset mid-lap
    rst_a = 1'b0; cyc(); rst_a = 1'b1;
    chk("rst2_done", a_done, 0);
    home();
    on_fin();
    cp(0);
    ticks(3);
    chk("mid_time", a_time, 3);
    chk("mid_mask", a_mask, 6'h01);
    rst_a = 1'b0; cyc(); rst_a = 1'b1;
    chk("mid_rst_mask", a_mask, 0);
    chk("mid_rst_time", a_time, 0);
    chk("mid_rst_laps", a_laps, 0);
    chk("mid_rst_last", a_last, 0);
    chk("mid_rst_best", a_best, 16'hFFFF);
    chk("mid_rst_done", a_done, 0);
    ticks(2);
    cp(1);
    chk("mid_wait_time", a_time, 0);
    chk("mid_wait_mask", a_mask, 0);

    // Ordered mode on instance B
    home();
    rst_b = 1'b1;
    on_fin();
    cp(2);
    chk("ord_cp2_first", b_mask, 0);
    cp(0);
    chk("ord_cp0", b_mask, 6'h01);
    cp(2);
    chk("ord_cp2_skip", b_mask, 6'h01);
    cp(1);
    chk("ord_cp1", b_mask, 6'h03);
    cp(2);
    chk("ord_cp2", b_mask, 6'h07);

    // Timer saturation on instance C
    home();
    rst_c = 1'b1;
    on_fin();
    ticks(14);
    chk("sat_14", c_time, 14);
    ticks(6);
    chk("sat_hold", c_time, 15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
